// File: rtl/uni_shf_pkg.sv
// Shared widths, types and stage direction for the uni_shf barrel shifter.
package uni_shf_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    typedef logic [DATA_W-1:0]  data_t;
    typedef logic [SHAMT_W-1:0] shamt_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

endpackage

// File: rtl/uni_shf_stage.sv
// One directional log barrel shifter: SHAMT_W mux levels, level i moves by 2**i.
// Define UNI_SHF_ROTATE_EN to rotate instead of zero-fill.
module uni_shf_stage
    import uni_shf_pkg::*;
#(
    parameter int   DATA_W  = 32,
    parameter int   SHAMT_W = $clog2(DATA_W),
    parameter dir_e DIR     = DIR_LEFT
) (
    input  logic [DATA_W-1:0]  d,
    input  logic [SHAMT_W-1:0] amt,
    input  logic               en,
    output logic [DATA_W-1:0]  q
);

    logic [DATA_W-1:0] stg [SHAMT_W+1];

    assign stg[0] = d;

    for (genvar i = 0; i < SHAMT_W; i++) begin : g_lvl
        localparam int S = 1 << i;
        logic [DATA_W-1:0] sh;

        // Constant-distance moves only; the amount bit just picks the mux leg.
        if (DIR == DIR_LEFT) begin : g_l
`ifdef UNI_SHF_ROTATE_EN
            assign sh = (stg[i] << S) | (stg[i] >> (DATA_W - S));
`else
            assign sh = stg[i] << S;
`endif
        end else begin : g_r
`ifdef UNI_SHF_ROTATE_EN
            assign sh = (stg[i] >> S) | (stg[i] << (DATA_W - S));
`else
            assign sh = stg[i] >> S;
`endif
        end

        assign stg[i+1] = amt[i] ? sh : stg[i];
    end

    assign q = en ? stg[SHAMT_W] : d;

endmodule

// File: rtl/uni_shf.sv
// Registered universal shifter: left stage, then right stage, then output flop.
// Define UNI_SHF_ROTATE_EN to turn both stages into rotators.
module uni_shf
    import uni_shf_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  in,
    input  logic               len,
    input  logic               ren,
    input  logic [SHAMT_W-1:0] svl,
    input  logic [SHAMT_W-1:0] svr,
    output logic [DATA_W-1:0]  out
);

    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;

    uni_shf_stage #(
        .DATA_W (DATA_W),
        .SHAMT_W(SHAMT_W),
        .DIR    (DIR_LEFT)
    ) u_lft (
        .d  (in),
        .amt(svl),
        .en (len),
        .q  (l)
    );

    uni_shf_stage #(
        .DATA_W (DATA_W),
        .SHAMT_W(SHAMT_W),
        .DIR    (DIR_RIGHT)
    ) u_rgt (
        .d  (l),
        .amt(svr),
        .en (ren),
        .q  (r)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) out <= '0;
        else     out <= r;
    end

endmodule

// File: tb/tb_uni_shf.sv
// Bench for uni_shf: directed table, hand-written reset/hold sequences, random vs model.
module tb_uni_shf;

`ifdef UNI_SHF_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] in;
    logic        len;
    logic        ren;
    logic [4:0]  svl;
    logic [4:0]  svr;
    logic [31:0] out;

    int checks = 0;
    int errors = 0;

    uni_shf dut (
        .clk(clk),
        .rst(rst),
        .in (in),
        .len(len),
        .ren(ren),
        .svl(svl),
        .svr(svr),
        .out(out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic        le;
        logic        re;
        logic [4:0]  sl;
        logic [4:0]  sr;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [11];

    // Reference: rotate via a doubled word, shifts via plain 32-bit operators.
    function automatic logic [31:0] model(input logic [31:0] a, input logic le, input logic re,
                                          input logic [4:0] sl, input logic [4:0] sr);
        logic [31:0] lv, rv;
        logic [63:0] w;
        lv = a;
        if (le) begin
            w  = {a, a} << sl;
            lv = ROT ? w[63:32] : (a << sl);
        end
        rv = lv;
        if (re) begin
            w  = {lv, lv} >> sr;
            rv = ROT ? w[31:0] : (lv >> sr);
        end
        return rv;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic le, input logic re,
                         input logic [4:0] sl, input logic [4:0] sr);
        in  = a;
        len = le;
        ren = re;
        svl = sl;
        svr = sr;
    endtask

    initial begin
        tbl[0]  = '{32'h1,        1, 0, 5'd1,  5'd0,  32'h0000_0002};
        tbl[1]  = '{32'h1,        1, 0, 5'd31, 5'd0,  32'h8000_0000};
        tbl[2]  = '{32'h8,        0, 1, 5'd0,  5'd1,  32'h0000_0004};
        tbl[3]  = '{32'h8,        0, 1, 5'd0,  5'd31, ROT ? 32'h0000_0010 : 32'h0};
        tbl[4]  = '{32'h3,        1, 1, 5'd31, 5'd31, ROT ? 32'h0000_0003 : 32'h1};
        tbl[5]  = '{32'h5,        0, 0, 5'd7,  5'd9,  32'h0000_0005};
        tbl[6]  = '{32'hFFFF_FFFF, 1, 1, 5'd0, 5'd0,  32'hFFFF_FFFF};
        tbl[7]  = '{32'h8000_0001, 1, 0, 5'd4, 5'd0,  ROT ? 32'h0000_0018 : 32'h0000_0010};
        tbl[8]  = '{32'h1234_5678, 0, 1, 5'd3, 5'd8,  ROT ? 32'h7812_3456 : 32'h0012_3456};
        tbl[9]  = '{32'hF000_0000, 0, 1, 5'd5, 5'd28, 32'h0000_000F};
        tbl[10] = '{32'h0000_00FF, 1, 1, 5'd8, 5'd4,  32'h0000_0FF0};

        rst = 1'b1;
        drive(32'h0, 0, 0, 5'd0, 5'd0);
        #2;
        check("reset_state", out, 32'h0);

        // A clock edge with rst high and a nonzero operand must not load.
        drive(32'h1, 0, 0, 5'd0, 5'd0);
        @(posedge clk); #1;
        check("reset_hold", out, 32'h0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        check("release_no_edge", out, 32'h0);

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(tbl[i].a, tbl[i].le, tbl[i].re, tbl[i].sl, tbl[i].sr);
            @(posedge clk); #1;
            check($sformatf("table_%0d", i), out, tbl[i].exp);
        end

        // Inputs changing between edges leave the registered value alone.
        @(negedge clk);
        drive(32'h0000_0040, 1, 0, 5'd2, 5'd0);
        @(posedge clk); #1;
        check("hold_load", out, 32'h0000_0100);
        drive(32'hDEAD_BEEF, 1, 1, 5'd3, 5'd5);
        #3;
        check("hold_between_edges", out, 32'h0000_0100);

        // Async reset mid-cycle, then release and reload.
        @(negedge clk);
        drive(32'h1, 1, 0, 5'd31, 5'd0);
        @(posedge clk); #1;
        check("pre_reset_value", out, 32'h8000_0000);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", out, 32'h0);
        drive(32'h1, 0, 0, 5'd0, 5'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_release_wait", out, 32'h0);
        @(posedge clk); #1;
        check("post_release_load", out, 32'h1);

        for (int k = 0; k < 400; k++) begin
            logic [31:0] a, e;
            logic        le, re;
            logic [4:0]  sl, sr;
            a  = $urandom;
            le = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            sl = 5'($urandom_range(0, 31));
            sr = 5'($urandom_range(0, 31));
            e  = model(a, le, re, sl, sr);
            @(negedge clk);
            drive(a, le, re, sl, sr);
            @(posedge clk); #1;
            check($sformatf("rand_%0d", k), out, e);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uni_shf.md
# uni_shf

Registered 32-bit universal barrel shifter. It can shift an input word left, right, or left-then-right by independent 5-bit amounts, selected by two enables. The result is registered on the clock edge. It sits in the datapath as a single-cycle shift unit feeding downstream logic from a flopped output.

## Interface
Parameters:
- `DATA_W`, default 32: data width. Must be a power of two.
- `SHAMT_W`, default `$clog2(DATA_W)` = 5: shift-amount width.

Ports:
- `clk`, input, 1 bit: single clock. Rising edge active.
- `rst`, input, 1 bit: reset, asynchronous and active-high.
- `in`, input, `DATA_W` bits: operand.
- `len`, input, 1 bit: left-shift enable.
- `ren`, input, 1 bit: right-shift enable.
- `svl`, input, `SHAMT_W` bits: left shift amount, 0..31.
- `svr`, input, `SHAMT_W` bits: right shift amount, 0..31.
- `out`, output, `DATA_W` bits: registered result.

## Operation
- Intermediate value `l`:
  - `in << svl` when `len` = 1.
  - `in` otherwise.
- Result `r`:
  - `l >> svr` when `ren` = 1.
  - `l` otherwise.
- Enable combinations:
  - `len`=0, `ren`=0: pass-through; `out` = `in`.
  - `len`=1, `ren`=0: left shift only.
  - `len`=0, `ren`=1: right shift only.
  - `len`=1, `ren`=1: left shift first, then right shift of that result. Bits shifted out by the left stage are lost.
- Default mode fills vacated positions with zeros on both sides. The right shift is logical.
- A shift amount of 0 is an identity.
- The maximum amount, 31, leaves one surviving bit.
- When a shift is disabled, its amount input is ignored.
- No X-propagation special handling: `in` is sampled as-is.
- Both shifts use log-stage muxing with `SHAMT_W` stages, not a variable `<<` operator.

## Timing
- Latency is 1 cycle: `out` reflects the inputs sampled at the previous rising `clk` edge.
- There is no handshake or valid. The result is accepted every cycle, with throughput of 1 per cycle.
- `rst` asserted: `out` is forced to 0 immediately, without waiting for a clock edge. It stays 0 while `rst` is high.
- `rst` deasserted: the first capture happens on the next rising edge.
- Input changes between edges do not affect `out` until the next edge.

## Configuration
- `UNI_SHF_ROTATE_EN` defined: both stages rotate instead of shift.
  - Bits leaving one end re-enter at the other.
  - Left rotate by `svl`, then right rotate by `svr`.
  - With both enables set, the net effect equals a rotate by `(svl - svr) mod 32`.
- `UNI_SHF_ROTATE_EN` undefined: zero-fill logical shifts as described under Operation.
- The reset value and latency are identical in both builds.

## Structure
- Package `uni_shf_pkg` holds:
  - constants `DATA_W` = 32 and `SHAMT_W` = 5;
  - typedefs `data_t` (`logic [DATA_W-1:0]`) and `shamt_t` (`logic [SHAMT_W-1:0]`).
- Sub-module `uni_shf_stage` is one directional log barrel shifter. It has:
  - parameter `DIR` (left or right);
  - inputs `d`, `amt`, `en`;
  - output `q`.
- The top module instantiates `uni_shf_stage` twice: left then right. The output register is in the top module.
- The rotate option is implemented inside the stage.

## Test plan
- `in`=1, `len`=1, `ren`=0, `svl`=1 → `out`=0x00000002 after the next edge. With `svl`=31 → `out`=0x80000000.
- `in`=8, `len`=0, `ren`=1, `svr`=1 → `out`=0x00000004. With `svr`=31 → `out`=0x00000000. With the macro defined → `out`=0x00000010.
- `in`=3, `len`=1, `svl`=31, `ren`=1, `svr`=31 → `out`=0x00000001: bit 1 is lost, bit 0 returns. With the macro defined → `out`=0x00000003.
- `in`=5, `len`=0, `ren`=0, `svl`=7, `svr`=9 → `out`=0x00000005, because the amounts are ignored.
- `in`=0xFFFFFFFF, `len`=1, `svl`=0, `ren`=1, `svr`=0 → `out`=0xFFFFFFFF (identity).
- After `out`=0x80000000, assert `rst` between edges → `out`=0 immediately. Release `rst` with `in`=1, `len`=0, `ren`=0 → `out`=1 after the next edge.
